// File: rtl/bp_pkg.sv
// Shared widths, types and helper functions for the dynamic branch predictor.
// Build option: define BP_GSHARE_EN to XOR global history into the BHT index.
package bp_pkg;

    // Build configuration of the predictor.
    localparam int unsigned ENTRIES = 64;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned GHR_W   = 6;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned STAT_W  = 32;

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    typedef logic [ADDR_W-1:0] addrT;
    typedef logic [IDX_W-1:0]  idxT;
    typedef logic [TAG_W-1:0]  tagT;
    typedef logic [CNT_W-1:0]  cntT;
    typedef logic [GHR_W-1:0]  ghrT;
    typedef logic [STAT_W-1:0] statT;

    typedef struct packed {
        logic valid;
        tagT  tag;
        addrT target;
    } btbEntryT;

    localparam cntT CNT_MAX  = '1;
    // Weakly not-taken; collapses to 0 for a 1-bit counter.
    localparam cntT CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

    function automatic idxT btb_index(addrT pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic tagT btb_tag(addrT pc);
        return pc[ADDR_W-1:IDX_W+2];
    endfunction

    function automatic idxT bp_index(addrT pc, ghrT ghr);
`ifdef BP_GSHARE_EN
        return pc[IDX_W+1:2] ^ IDX_W'(ghr);
`else
        return pc[IDX_W+1:2];
`endif
    endfunction

    // Saturating update; unconditional jumps pin the counter at strongly taken.
    function automatic cntT sat_next(cntT cnt, logic taken, logic jump);
        cntT res;
        res = cnt;
        if (jump) begin
            res = CNT_MAX;
        end else if (taken) begin
            if (cnt != CNT_MAX) res = cnt + CNT_W'(1);
        end else begin
            if (cnt != '0) res = cnt - CNT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, Execute feedback and statistics bundle between the core and the predictor.
interface branch_predictor_if;
    import bp_pkg::*;

    addrT pcf;
    logic pred_taken_f;
    logic pred_hit_f;
    addrT pred_next_pc_f;

    logic upd_valid_e;
    logic upd_is_jump_e;
    addrT upd_pc_e;
    logic upd_taken_e;
    addrT upd_target_e;
    logic pred_taken_e;
    addrT pred_next_pc_e;
    logic mispredict_e;
    addrT redirect_pc_e;

    statT stat_branches;
    statT stat_mispred;

    modport master (
        output pcf, upd_valid_e, upd_is_jump_e, upd_pc_e, upd_taken_e, upd_target_e,
               pred_taken_e, pred_next_pc_e,
        input  pred_taken_f, pred_hit_f, pred_next_pc_f, mispredict_e, redirect_pc_e,
               stat_branches, stat_mispred
    );

    modport slave (
        input  pcf, upd_valid_e, upd_is_jump_e, upd_pc_e, upd_taken_e, upd_target_e,
               pred_taken_e, pred_next_pc_e,
        output pred_taken_f, pred_hit_f, pred_next_pc_f, mispredict_e, redirect_pc_e,
               stat_branches, stat_mispred
    );
endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one combinational read port, one synchronous write port.
module bp_btb
    import bp_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  idxT      rdIdx,
    output btbEntryT rdEntry,
    input  logic     wrEn,
    input  idxT      wrIdx,
    input  btbEntryT wrEntry
);

    logic [ENTRIES-1:0] validQ;
    tagT                tagMem    [ENTRIES];
    addrT               targetMem [ENTRIES];

    // Only the valid bits need a reset; stale tags/targets are masked by valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validQ <= '0;
        end else if (wrEn) begin
            validQ[wrIdx] <= wrEntry.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            tagMem[wrIdx]    <= wrEntry.tag;
            targetMem[wrIdx] <= wrEntry.target;
        end
    end

    always_comb begin
        rdEntry.valid  = validQ[rdIdx];
        rdEntry.tag    = tagMem[rdIdx];
        rdEntry.target = targetMem[rdIdx];
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BHT of saturating counters plus tagged BTB, trained from Execute.
// Build option: BP_GSHARE_EN adds a non-speculative global history register to the BHT index.
module branch_predictor
    import bp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    branch_predictor_if.slave bp
);

    cntT      bht [ENTRIES];
    ghrT      ghrCur;
    btbEntryT lookEntry;
    btbEntryT wrEntry;
    idxT      bhtLookIdx;
    idxT      bhtUpdIdx;
    logic     lookHit;
    logic     lookTaken;
    addrT     fallThruF;
    addrT     fallThruE;
    addrT     redirectPc;
    logic     mispredict;
    logic     btbWrEn;
    statT     statBranchesQ;
    statT     statMispredQ;
    logic     unusedPredTaken;

    // Direction travels with the instruction but the redirect decision only needs the next PC.
    assign unusedPredTaken = bp.pred_taken_e;

`ifdef BP_GSHARE_EN
    ghrT ghrQ;

    // History advances only on resolved conditional branches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghrQ <= '0;
        end else if (bp.upd_valid_e && !bp.upd_is_jump_e) begin
            ghrQ <= GHR_W'({ghrQ, bp.upd_taken_e});
        end
    end

    assign ghrCur = ghrQ;
`else
    assign ghrCur = '0;
`endif

    bp_btb u_btb (
        .clk     (clk),
        .rst     (rst),
        .rdIdx   (btb_index(bp.pcf)),
        .rdEntry (lookEntry),
        .wrEn    (btbWrEn),
        .wrIdx   (btb_index(bp.upd_pc_e)),
        .wrEntry (wrEntry)
    );

    // Fetch-side lookup, zero cycle latency.
    always_comb begin
        fallThruF  = bp.pcf + ADDR_W'(4);
        bhtLookIdx = bp_index(bp.pcf, ghrCur);
        lookHit    = lookEntry.valid && (lookEntry.tag == btb_tag(bp.pcf));
        lookTaken  = lookHit && bht[bhtLookIdx][CNT_W-1];
    end

    assign bp.pred_hit_f     = lookHit;
    assign bp.pred_taken_f   = lookTaken;
    assign bp.pred_next_pc_f = lookTaken ? lookEntry.target : fallThruF;

    // Execute-side resolution and flush request.
    always_comb begin
        fallThruE  = bp.upd_pc_e + ADDR_W'(4);
        redirectPc = bp.upd_taken_e ? bp.upd_target_e : fallThruE;
        mispredict = bp.upd_valid_e && (bp.pred_next_pc_e != redirectPc);
        bhtUpdIdx  = bp_index(bp.upd_pc_e, ghrCur);
        btbWrEn    = bp.upd_valid_e && bp.upd_taken_e;
        wrEntry.valid  = 1'b1;
        wrEntry.tag    = btb_tag(bp.upd_pc_e);
        wrEntry.target = bp.upd_target_e;
    end

    assign bp.mispredict_e  = mispredict;
    assign bp.redirect_pc_e = redirectPc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                bht[IDX_W'(i)] <= CNT_INIT;
            end
        end else if (bp.upd_valid_e) begin
            bht[bhtUpdIdx] <= sat_next(bht[bhtUpdIdx], bp.upd_taken_e, bp.upd_is_jump_e);
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            statBranchesQ <= '0;
            statMispredQ  <= '0;
        end else begin
            if (bp.upd_valid_e && (statBranchesQ != '1)) begin
                statBranchesQ <= statBranchesQ + STAT_W'(1);
            end
            if (mispredict && (statMispredQ != '1)) begin
                statMispredQ <= statMispredQ + STAT_W'(1);
            end
        end
    end

    assign bp.stat_branches = statBranchesQ;
    assign bp.stat_mispred  = statMispredQ;

endmodule
